// File: rtl/tjrpu_wb_mailbox.sv
// Wishbone slave mailbox between the management SoC and the tjrpu core.
// Two FWFT FIFOs (host-to-core, core-to-host), status, sticky error flags and a maskable IRQ.
module tjrpu_wb_mailbox #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] h2c_data_o,
  output logic        h2c_valid_o,
  input  logic        h2c_ready_i,
  input  logic [31:0] c2h_data_i,
  input  logic        c2h_valid_i,
  output logic        c2h_ready_o,
  output logic        irq_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    REG_DATA     = 2'd0,
    REG_STATUS   = 2'd1,
    REG_IRQ_EN   = 2'd2,
    REG_IRQ_STAT = 2'd3
  } reg_e;

  logic [31:0]   h2c_mem [DEPTH];
  logic [31:0]   c2h_mem [DEPTH];
  logic [PW-1:0] h2c_wp, h2c_rp, c2h_wp, c2h_rp;
  logic [CW-1:0] h2c_cnt, c2h_cnt;
  logic [3:0]    irq_en;
  logic          ovf, unf;

  logic          req, wr, rd;
  reg_e          reg_sel;
  logic          h2c_full, h2c_empty, c2h_full, c2h_empty;
  logic          h2c_push_req, h2c_push, h2c_pop;
  logic          c2h_pop_req, c2h_pop, c2h_push;
  logic          ovf_set, unf_set, stat_wr;
  logic [3:0]    irq_stat_c;
  logic [31:0]   status_c;
  logic [31:0]   rd_data_c;
  logic          unused_adr;

  // Bus decode: one request per access, ack blocks back-to-back requests
  assign req       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs_ack_o;
  assign wr        = req & wbs_we_i;
  assign rd        = req & ~wbs_we_i;
  assign reg_sel   = reg_e'(wbs_adr_i[3:2]);
  assign unused_adr = ^wbs_adr_i[1:0];

  assign h2c_full  = (h2c_cnt == CW'(DEPTH));
  assign h2c_empty = (h2c_cnt == '0);
  assign c2h_full  = (c2h_cnt == CW'(DEPTH));
  assign c2h_empty = (c2h_cnt == '0);

  assign h2c_valid_o = ~h2c_empty;
  assign h2c_data_o  = h2c_mem[h2c_rp];
  assign h2c_pop     = h2c_valid_o & h2c_ready_i;

  // A full FIFO still accepts a push when the other side pops in the same cycle
  assign h2c_push_req = wr & (reg_sel == REG_DATA) & (wbs_sel_i == 4'hF);
  assign h2c_push     = h2c_push_req & (~h2c_full | h2c_pop);
  assign ovf_set      = h2c_push_req & ~h2c_push;

  assign c2h_pop_req  = rd & (reg_sel == REG_DATA);
  assign c2h_pop      = c2h_pop_req & ~c2h_empty;
  assign unf_set      = c2h_pop_req & c2h_empty;
  assign c2h_ready_o  = ~c2h_full | c2h_pop;
  assign c2h_push     = c2h_valid_i & c2h_ready_o;

  assign stat_wr    = wr & (reg_sel == REG_IRQ_STAT);
  assign irq_stat_c = {unf, ovf, h2c_empty, ~c2h_empty};
  assign status_c   = {8'h00, 8'(c2h_cnt), 8'(h2c_cnt), 4'h0,
                       c2h_empty, c2h_full, h2c_empty, h2c_full};

  // Read data mux; an empty c2h pop reads as zero
  always_comb begin
    rd_data_c = '0;
    case (reg_sel)
      REG_DATA:     rd_data_c = c2h_empty ? 32'h0 : c2h_mem[c2h_rp];
      REG_STATUS:   rd_data_c = status_c;
      REG_IRQ_EN:   rd_data_c = {28'h0, irq_en};
      REG_IRQ_STAT: rd_data_c = {28'h0, irq_stat_c};
      default:      rd_data_c = '0;
    endcase
  end

  // FIFO storage carries no reset
  always_ff @(posedge wb_clk_i) begin
    if (h2c_push) h2c_mem[h2c_wp] <= wbs_dat_i;
    if (c2h_push) c2h_mem[c2h_wp] <= c2h_data_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      h2c_wp  <= '0;
      h2c_rp  <= '0;
      h2c_cnt <= '0;
    end else begin
      if (h2c_push) h2c_wp <= h2c_wp + PW'(1);
      if (h2c_pop)  h2c_rp <= h2c_rp + PW'(1);
      if (h2c_push && !h2c_pop)      h2c_cnt <= h2c_cnt + CW'(1);
      else if (!h2c_push && h2c_pop) h2c_cnt <= h2c_cnt - CW'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      c2h_wp  <= '0;
      c2h_rp  <= '0;
      c2h_cnt <= '0;
    end else begin
      if (c2h_push) c2h_wp <= c2h_wp + PW'(1);
      if (c2h_pop)  c2h_rp <= c2h_rp + PW'(1);
      if (c2h_push && !c2h_pop)      c2h_cnt <= c2h_cnt + CW'(1);
      else if (!c2h_push && c2h_pop) c2h_cnt <= c2h_cnt - CW'(1);
    end
  end

  // Bus response, control registers and interrupt; flag set beats W1C
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_en    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      if (rd) wbs_dat_o <= rd_data_c;
      if (wr && reg_sel == REG_IRQ_EN && wbs_sel_i[0]) irq_en <= wbs_dat_i[3:0];
      ovf   <= ovf_set | (ovf & ~(stat_wr & wbs_dat_i[2]));
      unf   <= unf_set | (unf & ~(stat_wr & wbs_dat_i[3]));
      irq_o <= |(irq_stat_c & irq_en);
    end
  end

endmodule

// File: tb/tb_tjrpu_wb_mailbox.sv
// Scoreboard bench for tjrpu_wb_mailbox: queue-based reference model, decoupled monitors.
module tb_tjrpu_wb_mailbox;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we_s;
  logic [3:0]  sel_s;
  logic [31:0] adr, dat_s;
  logic        ack;
  logic [31:0] dat_o;
  logic [31:0] h2c_data;
  logic        h2c_valid, h2c_ready;
  logic [31:0] c2h_data;
  logic        c2h_valid, c2h_ready;
  logic        irq;

  always #5 clk = ~clk;

  tjrpu_wb_mailbox #(.BASE_ADDR(BASE), .DEPTH_LOG2(3)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we_s), .wbs_sel_i(sel_s),
    .wbs_adr_i(adr), .wbs_dat_i(dat_s), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .h2c_data_o(h2c_data), .h2c_valid_o(h2c_valid), .h2c_ready_i(h2c_ready),
    .c2h_data_i(c2h_data), .c2h_valid_i(c2h_valid), .c2h_ready_o(c2h_ready),
    .irq_o(irq)
  );

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  exp_t        rd_q[$];
  logic [31:0] h2c_q[$];
  logic [31:0] c2h_q[$];
  bit          ovf_m, unf_m, h2c_pop_pending;
  logic [3:0]  en_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] stat_m();
    return {28'h0, unf_m, ovf_m, h2c_q.size() == 0, c2h_q.size() != 0};
  endfunction

  function automatic logic [31:0] status_m();
    logic [7:0] hc, cc;
    hc = 8'(h2c_q.size());
    cc = 8'(c2h_q.size());
    return {8'h00, cc, hc, 4'h0, c2h_q.size() == 0, c2h_q.size() == DEPTH,
            h2c_q.size() == 0, h2c_q.size() == DEPTH};
  endfunction

  // Monitors: bus acks pop the read scoreboard, core handshakes pop the h2c model
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && ack) begin
      if (rd_q.size() == 0) chk("stray_ack", 32'(ack), 32'd0);
      else begin
        e = rd_q.pop_front();
        if (e.chk) chk(e.nm, dat_o, e.exp);
      end
    end
    if (rst_n && h2c_valid && h2c_ready) begin
      if (h2c_q.size() == 0) chk("h2c_unexpected", 32'(h2c_valid), 32'd0);
      else chk("h2c_data", h2c_data, h2c_q.pop_front());
    end
  end

  task automatic wb_access(input logic [3:0] off, input bit we, input logic [31:0] dat,
                           input logic [3:0] sel, input bit chk_rd, input logic [31:0] exp,
                           input string nm);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we_s = we; adr = BASE + 32'(off); dat_s = dat; sel_s = sel;
    e.chk = chk_rd; e.exp = exp; e.nm = nm;
    rd_q.push_back(e);
    n = 0;
    while (n < 16) begin
      @(posedge clk); #1;
      if (ack) break;
      n++;
    end
    chk({nm, "_ack_lat"}, 32'(n), 32'd0);
    cyc = 1'b0; stb = 1'b0; we_s = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_ack_len"}, 32'(ack), 32'd0);
  endtask

  task automatic host_read(input logic [3:0] off, input string nm);
    logic [31:0] exp;
    exp = '0;
    case (off)
      4'd0: if (c2h_q.size() == 0) begin exp = 32'h0; unf_m = 1'b1; end
            else exp = c2h_q.pop_front();
      4'd4: exp = status_m();
      4'd8: exp = {28'h0, en_m};
      default: exp = stat_m();
    endcase
    wb_access(off, 1'b0, 32'h0, 4'hF, 1'b1, exp, nm);
  endtask

  task automatic host_write(input logic [3:0] off, input logic [31:0] dat,
                            input logic [3:0] sel, input string nm);
    case (off)
      4'd0: if (sel == 4'hF) begin
              if (h2c_q.size() < DEPTH || h2c_pop_pending) h2c_q.push_back(dat);
              else ovf_m = 1'b1;
            end
      4'd8: if (sel[0]) en_m = dat[3:0];
      4'd12: begin
        if (dat[2]) ovf_m = 1'b0;
        if (dat[3]) unf_m = 1'b0;
      end
      default: ;
    endcase
    wb_access(off, 1'b1, dat, sel, 1'b0, 32'h0, nm);
  endtask

  task automatic core_push(input logic [31:0] d);
    int n;
    @(posedge clk); #1;
    c2h_valid = 1'b1; c2h_data = d;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (c2h_ready) break;
      n++;
    end
    chk("c2h_ready_wait", 32'(n < 50), 32'd1);
    if (n < 50) c2h_q.push_back(d);
    @(posedge clk); #1;
    c2h_valid = 1'b0;
  endtask

  task automatic drain_h2c(input string nm);
    int n;
    h2c_ready = 1'b1;
    n = 0;
    while (h2c_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    h2c_ready = 1'b0;
    chk(nm, 32'(h2c_q.size()), 32'd0);
  endtask

  task automatic chk_irq(input string nm);
    chk(nm, 32'(irq), 32'(|(stat_m() & en_m)));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] off;
    int         n_ack;
    cyc = 0; stb = 0; we_s = 0; sel_s = 0; adr = 0; dat_s = 0;
    h2c_ready = 0; c2h_valid = 0; c2h_data = 0;
    ovf_m = 0; unf_m = 0; en_m = 0; h2c_pop_pending = 0;
    rst_n = 1'b0;
    #22;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_h2c_valid", 32'(h2c_valid), 32'd0);
    chk("rst_c2h_ready", 32'(c2h_ready), 32'd1);
    rst_n = 1'b1;

    host_read(4'd4, "t1_status");

    for (int i = 0; i < 9; i++) host_write(4'd0, 32'h100 + 32'(i), 4'hF, "t2_wr");
    host_read(4'd4, "t2_status");
    host_read(4'd12, "t2_irq_stat");
    drain_h2c("t2_drained");

    host_write(4'd8, 32'h1, 4'hF, "t3_en");
    core_push(32'hDEAD_BEEF);
    chk("t3_irq_lag", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk("t3_irq_rise", 32'(irq), 32'd1);
    host_read(4'd0, "t3_data");
    chk("t3_irq_fall", 32'(irq), 32'd0);

    host_read(4'd0, "t4_empty_rd");
    host_read(4'd12, "t4_stat_unf");
    host_write(4'd12, 32'h8, 4'hF, "t4_w1c");
    host_read(4'd12, "t4_stat_clr");

    // Host push into full h2c while the core pops in the same cycle
    host_write(4'd12, 32'h4, 4'hF, "t2b_clr_ovf");
    for (int i = 0; i < DEPTH; i++) host_write(4'd0, $urandom, 4'hF, "t2b_fill");
    h2c_pop_pending = 1'b1;
    fork
      host_write(4'd0, 32'hA5A5_0001, 4'hF, "t2b_race");
      begin
        @(posedge clk); #1 h2c_ready = 1'b1;
        @(posedge clk); #1 h2c_ready = 1'b0;
      end
    join
    h2c_pop_pending = 1'b0;
    host_read(4'd12, "t2b_no_ovf");
    host_read(4'd4, "t2b_status");
    drain_h2c("t2b_drained");

    // c2h empty race: only the core push lands
    fork
      host_read(4'd0, "t5_empty_race");
      core_push($urandom);
    join
    for (int i = 1; i < DEPTH; i++) core_push($urandom);
    chk("t5_full_ready", 32'(c2h_ready), 32'd0);
    for (int i = 0; i < 20; i++) begin
      fork
        host_read(4'd0, "t5_wrap_rd");
        core_push($urandom);
      join
    end
    host_read(4'd4, "t5_status");
    for (int i = 0; i < DEPTH; i++) host_read(4'd0, "t5_drain");
    host_write(4'd12, 32'hC, 4'hF, "t5_w1c");
    host_read(4'd12, "t5_stat");

    // Randomized mix against the model
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: host_write(4'd0, $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, "rnd_wr");
        1: host_read(4'd0, "rnd_rd");
        2: if (c2h_q.size() < DEPTH) core_push($urandom);
        3: begin
          off = ($urandom_range(0, 1) == 0) ? 4'd4 : 4'd12;
          host_read(off, "rnd_reg_rd");
        end
        default: begin
          off = ($urandom_range(0, 1) == 0) ? 4'd8 : 4'd12;
          host_write(off, $urandom, 4'($urandom), "rnd_reg_wr");
        end
      endcase
      @(posedge clk); #1;
      chk_irq("rnd_irq");
    end
    drain_h2c("rnd_h2c_drained");
    while (c2h_q.size() > 0) host_read(4'd0, "rnd_c2h_drain");
    host_read(4'd4, "rnd_status");

    // Out-of-window access is never acked
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we_s = 1'b0; sel_s = 4'hF; adr = BASE + 32'h10;
    n_ack = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack) n_ack++;
    end
    chk("t6_no_ack", 32'(n_ack), 32'd0);
    cyc = 1'b0; stb = 1'b0;

    // Reset in the middle of an access
    host_write(4'd0, 32'h1234_5678, 4'hF, "t6_pre_wr");
    core_push(32'h8765_4321);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we_s = 1'b0; adr = BASE + 32'h4;
    @(posedge clk); #1;
    chk("t6_ack_before_rst", 32'(ack), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_ack_async_drop", 32'(ack), 32'd0);
    chk("t6_h2c_empty", 32'(h2c_valid), 32'd0);
    chk("t6_c2h_ready", 32'(c2h_ready), 32'd1);
    chk("t6_irq", 32'(irq), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    h2c_q.delete(); c2h_q.delete();
    ovf_m = 0; unf_m = 0; en_m = 0;
    #13 rst_n = 1'b1;
    host_read(4'd4, "t6_status");
    host_read(4'd8, "t6_irq_en");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
